mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_pkg.sv | 13 +
 rtl/mem_port_timer.sv | 32 +++
 rtl/mem_port_ctrl.sv | 119 +++++++++++
 tb/tb_mem_port_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the CPU-to-memory port controller.
package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] MEM_ERR_DATA    = 32'hDEAD_BEEF;
    localparam int          DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_timer.sv
// BUSY-cycle counter used by the optional timeout abort (MEM_PORT_TIMEOUT_EN).
module mem_port_timer
    import mem_port_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // count holds the number of BUSY cycles already completed, so expiry
    // is flagged during the TIMEOUT-th BUSY cycle itself.
    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: stalls the CPU while a single registered memory access runs.
// Define MEM_PORT_TIMEOUT_EN to abort BUSY after TIMEOUT cycles with cpu_err.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    state_t next_state;
    logic   timeout_hit;
    logic   unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

`ifdef MEM_PORT_TIMEOUT_EN
    mem_port_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != BUSY),
        .enable (state == BUSY),
        .expired(timeout_hit)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign cpu_err     = 1'b0;
`endif

    assign cpu_stall = ((state == IDLE) && cpu_req) || (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_req) next_state = BUSY;
            BUSY:    if (mem_ready || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // mem_ready takes priority over a coinciding timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_valid <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr[ADDR_W-1:0];
                        mem_wdata <= cpu_wdata;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        cpu_ack   <= 1'b1;
                        if (!mem_we) cpu_rdata <= mem_rdata;
                    end else if (timeout_hit) begin
                        mem_valid <= 1'b0;
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= DATA_W'(MEM_ERR_DATA);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_PORT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_err <= 1'b0;
        end else if ((state == IDLE) && cpu_req) begin
            cpu_err <= 1'b0;
        end else if ((state == BUSY) && !mem_ready && timeout_hit) begin
            cpu_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench for mem_port_ctrl (ADDR_W=6, DATA_W=32, TIMEOUT=4).
module tb_mem_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_valid;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_ctrl #(
        .ADDR_W (6),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .cpu_err  (cpu_err),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        checks++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_err, cpu_rdata, cpu_stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b we=%b addr=%h wdata=%h ack=%b err=%b rdata=%h stall=%b expected all 0",
                     mem_valid, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_err, cpu_rdata, cpu_stall);
        end
        #11 rst_n = 1'b1;
        tick();
        checks++;
        if (mem_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b stall=%b expected 0 0", mem_valid, cpu_stall);
        end
    endtask

    task automatic test_read_zero_wait();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd0_cycle0: got stall=%b valid=%b expected 1 0", cpu_stall, mem_valid);
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd5 || cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd0_cycle1: got valid=%b we=%b addr=%h stall=%b ack=%b expected 1 0 05 1 0",
                     mem_valid, mem_we, mem_addr, cpu_stall, cpu_ack);
        end
        tick();
        cpu_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1234_5678 || cpu_stall !== 1'b0 || mem_valid !== 1'b0 || cpu_err !== 1'b0) begin
            errors++;
            $display("FAIL rd0_cycle2: got ack=%b rdata=%h stall=%b valid=%b err=%b expected 1 12345678 0 0 0",
                     cpu_ack, cpu_rdata, cpu_stall, mem_valid, cpu_err);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL rd0_cycle3: got ack=%b stall=%b expected 0 0", cpu_ack, cpu_stall);
        end
    endtask

    task automatic test_write_wait3();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd9; cpu_wdata = 32'hA5A5_A5A5;
        tick();
        cpu_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            mem_rdata = 32'hFFFF_0000;
            #1;
            checks++;
            if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd9 || mem_wdata !== 32'hA5A5_A5A5 ||
                cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin
                errors++;
                $display("FAIL wr_busy%0d: got valid=%b we=%b addr=%h wdata=%h ack=%b stall=%b expected 1 1 09 a5a5a5a5 0 1",
                         i, mem_valid, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_stall);
            end
            tick();
        end
        cpu_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1234_5678 || cpu_err !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: got ack=%b rdata=%h err=%b valid=%b expected 1 12345678 0 0",
                     cpu_ack, cpu_rdata, cpu_err, mem_valid);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_after: got ack=%b expected 0", cpu_ack);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_valid;
        logic [6:0] exp_ack;
        exp_valid = 7'b0010010;
        exp_ack   = 7'b0100100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
        mem_ready = 1'b0; mem_rdata = 32'h0000_00AA;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) mem_ready = 1'b1;
            if (c == 4) mem_rdata = 32'h0000_00BB;
            if (c == 5) begin cpu_req = 1'b0; mem_ready = 1'b0; end
            #1;
            checks++;
            if (mem_valid !== exp_valid[c] || cpu_ack !== exp_ack[c]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got valid=%b ack=%b expected %b %b",
                         c, mem_valid, cpu_ack, exp_valid[c], exp_ack[c]);
            end
            if (c == 2) begin
                checks++;
                if (cpu_rdata !== 32'h0000_00AA || cpu_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first: got rdata=%h stall=%b expected 000000aa 0", cpu_rdata, cpu_stall);
                end
            end
            if (c == 5) begin
                checks++;
                if (cpu_rdata !== 32'h0000_00BB) begin
                    errors++;
                    $display("FAIL b2b_second: got rdata=%h expected 000000bb", cpu_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_busy();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7; mem_ready = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_err, cpu_rdata, cpu_stall} !== '0) begin
            errors++;
            $display("FAIL rst_busy_async: got valid=%b addr=%h ack=%b rdata=%h stall=%b expected all 0",
                     mem_valid, mem_addr, cpu_ack, cpu_rdata, cpu_stall);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_noack: got ack=%b valid=%b expected 0 0", cpu_ack, mem_valid);
        end
        #2 rst_n = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_addr = 32'd2;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 6'd2) begin
            errors++;
            $display("FAIL rst_fresh_busy: got valid=%b addr=%h expected 1 02", mem_valid, mem_addr);
        end
        tick();
        cpu_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL rst_fresh_done: got ack=%b rdata=%h expected 1 0f0f0f0f", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

`ifdef MEM_PORT_TIMEOUT_EN
    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_valid !== 1'b1 || cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL to_busy%0d: got valid=%b ack=%b expected 1 0", i, mem_valid, cpu_ack);
            end
            tick();
        end
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: got ack=%b err=%b rdata=%h valid=%b expected 1 1 deadbeef 0",
                     cpu_ack, cpu_err, cpu_rdata, mem_valid);
        end
        tick();
        checks++;
        if (cpu_err !== 1'b1 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL to_err_hold: got err=%b ack=%b expected 1 0", cpu_err, cpu_ack);
        end
        cpu_req = 1'b1; cpu_addr = 32'd4;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3); mem_rdata = 32'h0000_0055;
            #1;
            checks++;
            if (cpu_err !== 1'b0 || mem_valid !== 1'b1) begin
                errors++;
                $display("FAIL to_edge_busy%0d: got err=%b valid=%b expected 0 1", i, cpu_err, mem_valid);
            end
            tick();
        end
        cpu_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0000_0055) begin
            errors++;
            $display("FAIL to_edge_done: got ack=%b err=%b rdata=%h expected 1 0 00000055", cpu_ack, cpu_err, cpu_rdata);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (mem_valid !== 1'b1 || cpu_ack !== 1'b0 || cpu_err !== 1'b0 || cpu_stall !== 1'b1) begin
                errors++;
                $display("FAIL wait_busy%0d: got valid=%b ack=%b err=%b stall=%b expected 1 0 0 1",
                         i, mem_valid, cpu_ack, cpu_err, cpu_stall);
            end
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        cpu_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0000_0077) begin
            errors++;
            $display("FAIL wait_done: got ack=%b err=%b rdata=%h expected 1 0 00000077", cpu_ack, cpu_err, cpu_rdata);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_back_to_back();
        test_reset_busy();
`ifdef MEM_PORT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
